// File: rtl/path_read_buffer.sv
// path_read_buffer
//
// Read-side path buffer between the DRAM read-data port and the Path ORAM
// backend. DRAM read beats cannot be backpressured, so they are absorbed into
// a circular FIFO and offered downstream with a valid/ready handshake.
//
// There are two release modes:
//   stream - a beat is offered as soon as it is buffered.
//   gate   - nothing is offered until a whole path (PathBursts beats) is
//            buffered. This hides DRAM read timing from the backend.
// The mode is only sampled when the buffer is empty and sits on a path
// boundary, so a path is never released under mixed rules.
//
// Optional build macro: PATH_READ_BUFFER_HWM_EN adds the HighWater output,
// a registered peak of Occupancy since reset.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   GateMode   in   1 = gate mode, 0 = stream mode (latched at path boundary)
//   InData     in   DRAM read beat
//   InValid    in   beat present (written whenever space exists)
//   InAccept   out  advisory, ~Full
//   OutData    out  head beat
//   OutValid   out  head beat is releasable
//   OutReady   in   downstream accepts; transfer on OutValid & OutReady
//   PathDone   out  one-cycle pulse after the last beat of a path is popped
//   Occupancy  out  beats currently stored
//   PathsReady out  complete paths buffered and not yet fully drained
//   Overflow   out  sticky, set when a beat is dropped
//   HighWater  out  (HWM build only) peak Occupancy since reset
module path_read_buffer #(
  parameter int Width      = 512,
  parameter int Depth      = 64,
  parameter int PathBursts = 64,
  parameter int OccWidth   = $clog2(Depth + 1)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                GateMode,
  input  logic [Width-1:0]    InData,
  input  logic                InValid,
  output logic                InAccept,
  output logic [Width-1:0]    OutData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                PathDone,
  output logic [OccWidth-1:0] Occupancy,
  output logic [OccWidth-1:0] PathsReady,
  output logic                Overflow
`ifdef PATH_READ_BUFFER_HWM_EN
  ,
  output logic [OccWidth-1:0] HighWater
`endif
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = (PathBursts > 1) ? $clog2(PathBursts) : 1;
  localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] LastBeat  = CntWidth'(PathBursts - 1);
  localparam logic [OccWidth-1:0] FullCount = OccWidth'(Depth);

  logic [Width-1:0] mem [Depth];

  logic [PtrWidth-1:0] wrPtrReg;
  logic [PtrWidth-1:0] rdPtrReg;
  logic [OccWidth-1:0] countReg;
  logic [OccWidth-1:0] pathsReadyReg;
  logic [CntWidth-1:0] inCntReg;
  logic [CntWidth-1:0] outCntReg;
  logic                gateReg;
  logic                overflowReg;
  logic                pathDoneReg;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic pathIn;
  logic pathOut;
  logic atBoundary;

  assign empty = (countReg == '0);
  assign full  = (countReg == FullCount);

  // Release depends only on registered state, so OutValid can only fall
  // through a pop: in gate mode PathsReady drops only on the final pop of a
  // path, and the mode can only change while the buffer is empty.
  assign OutValid = ~empty & (~gateReg | (pathsReadyReg != '0));
  assign pop      = OutValid & OutReady;

  // A full buffer still takes a beat in the same cycle a beat leaves.
  assign push = InValid & (~full | pop);
  assign drop = InValid & full & ~pop;

  assign pathIn     = push & (inCntReg == LastBeat);
  assign pathOut    = pop & (outCntReg == LastBeat);
  assign atBoundary = empty & (inCntReg == '0) & (outCntReg == '0);

  // Storage has no reset; contents are meaningless until written. The head
  // is read combinationally so a beat is visible the cycle after its write.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wrPtrReg] <= InData;
    end
  end

  assign OutData = mem[rdPtrReg];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
      countReg      <= '0;
      pathsReadyReg <= '0;
      inCntReg      <= '0;
      outCntReg     <= '0;
      gateReg       <= 1'b0;
      overflowReg   <= 1'b0;
      pathDoneReg   <= 1'b0;
    end else begin
      if (push) begin
        wrPtrReg <= (wrPtrReg == LastPtr) ? '0 : wrPtrReg + PtrWidth'(1);
        inCntReg <= (inCntReg == LastBeat) ? '0 : inCntReg + CntWidth'(1);
      end
      if (pop) begin
        rdPtrReg  <= (rdPtrReg == LastPtr) ? '0 : rdPtrReg + PtrWidth'(1);
        outCntReg <= (outCntReg == LastBeat) ? '0 : outCntReg + CntWidth'(1);
      end

      case ({push, pop})
        2'b10:   countReg <= countReg + OccWidth'(1);
        2'b01:   countReg <= countReg - OccWidth'(1);
        default: countReg <= countReg;
      endcase

      case ({pathIn, pathOut})
        2'b10:   pathsReadyReg <= pathsReadyReg + OccWidth'(1);
        2'b01:   pathsReadyReg <= pathsReadyReg - OccWidth'(1);
        default: pathsReadyReg <= pathsReadyReg;
      endcase

      pathDoneReg <= pathOut;

      if (drop) begin
        overflowReg <= 1'b1;
      end

      if (atBoundary) begin
        gateReg <= GateMode;
      end
    end
  end

  assign InAccept   = ~full;
  assign PathDone   = pathDoneReg;
  assign Occupancy  = countReg;
  assign PathsReady = pathsReadyReg;
  assign Overflow   = overflowReg;

`ifdef PATH_READ_BUFFER_HWM_EN
  logic [OccWidth-1:0] highWaterReg;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      highWaterReg <= '0;
    end else if (countReg > highWaterReg) begin
      highWaterReg <= countReg;
    end
  end

  assign HighWater = highWaterReg;
`endif

endmodule

// File: tb/tb_path_read_buffer.sv
module tb_path_read_buffer;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int PB = 4;
  localparam int OW = $clog2(D + 1);

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          GateMode = 1'b0;
  logic [W-1:0]  InData = '0;
  logic          InValid = 1'b0;
  logic          InAccept;
  logic [W-1:0]  OutData;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic          PathDone;
  logic [OW-1:0] Occupancy;
  logic [OW-1:0] PathsReady;
  logic          Overflow;
`ifdef PATH_READ_BUFFER_HWM_EN
  logic [OW-1:0] HighWater;
`endif

  always #5 Clock = ~Clock;

  path_read_buffer #(
    .Width(W), .Depth(D), .PathBursts(PB)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .GateMode(GateMode),
    .InData(InData),
    .InValid(InValid),
    .InAccept(InAccept),
    .OutData(OutData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .PathDone(PathDone),
    .Occupancy(Occupancy),
    .PathsReady(PathsReady),
    .Overflow(Overflow)
`ifdef PATH_READ_BUFFER_HWM_EN
    ,
    .HighWater(HighWater)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a queue of buffered beats plus running totals of
  // accepted and released beats since reset.
  logic [W-1:0] q[$];
  int wrTotal;
  int popTotal;
  int hwM;
  bit gateM;
  bit ovfM;
  bit pdM;
  int pdSeen;

  function automatic int expPathsReady();
    return (wrTotal / PB) - (popTotal / PB);
  endfunction

  function automatic bit expValid();
    return (q.size() > 0) && (!gateM || expPathsReady() > 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    wrTotal = 0;
    popTotal = 0;
    hwM = 0;
    gateM = 1'b0;
    ovfM = 1'b0;
    pdM = 1'b0;
  endtask

  task automatic compare();
    chk("OutValid", int'(OutValid), int'(expValid()));
    chk("Occupancy", int'(Occupancy), q.size());
    chk("PathsReady", int'(PathsReady), expPathsReady());
    chk("InAccept", int'(InAccept), int'(q.size() < D));
    chk("Overflow", int'(Overflow), int'(ovfM));
    chk("PathDone", int'(PathDone), int'(pdM));
    if (expValid()) chk("OutData", int'(OutData), int'(q[0]));
`ifdef PATH_READ_BUFFER_HWM_EN
    chk("HighWater", int'(HighWater), hwM);
`endif
    if (PathDone) pdSeen++;
  endtask

  // One clock: drive inputs, step the model at the edge, compare at negedge.
  task automatic cycle(input bit iv, input logic [W-1:0] d, input bit rdy, input bit gm);
    int sz;
    bit full, pop, wr, latch;
    logic [W-1:0] popped;
    InValid = iv;
    InData = d;
    OutReady = rdy;
    GateMode = gm;
    sz = q.size();
    full = (sz == D);
    pop = expValid() && rdy;
    wr = iv && (!full || pop);
    latch = (sz == 0) && (wrTotal % PB == 0) && (popTotal % PB == 0);
    @(posedge Clock);
    if (Reset_n) begin
      if (sz > hwM) hwM = sz;
      pdM = pop && ((popTotal + 1) % PB == 0);
      if (pop) begin
        popped = q.pop_front();
        popTotal++;
        $display("xfer %0d data=%h", popTotal, popped);
      end
      if (wr) begin
        q.push_back(d);
        wrTotal++;
      end
      if (iv && full && !pop) ovfM = 1'b1;
      if (latch) gateM = gm;
    end
    @(negedge Clock);
    compare();
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    #1;
    modelReset();
    chk("rst_OutValid", int'(OutValid), 0);
    chk("rst_Occupancy", int'(Occupancy), 0);
    chk("rst_PathsReady", int'(PathsReady), 0);
    chk("rst_InAccept", int'(InAccept), 1);
    chk("rst_Overflow", int'(Overflow), 0);
    chk("rst_PathDone", int'(PathDone), 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    Reset_n = 1'b1;
  endtask

  initial begin
    bit gm;
    modelReset();
    pdSeen = 0;
    @(negedge Clock);
    doReset();

    // Stream mode: four back-to-back beats, each released the next cycle.
    cycle(1'b1, 16'h00A0, 1'b1, 1'b0);
    chk("stream_occ_peak", int'(Occupancy), 1);
    chk("stream_first_valid", int'(OutValid), 1);
    chk("stream_first_data", int'(OutData), 16'h00A0);
    pdSeen = 0;
    for (int k = 1; k < 4; k++) cycle(1'b1, W'(16'h00A0 + k), 1'b1, 1'b0);
    chk("stream_occ_hold", int'(Occupancy), 1);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_pathdone_count", pdSeen, 1);

    // Gate mode: one beat every three cycles, nothing released until the 4th.
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, W'(16'h00B0 + k), 1'b1, 1'b1);
      if (k < 3) begin
        chk("gate_held", int'(OutValid), 0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
      end
    end
    chk("gate_release", int'(OutValid), 1);
    chk("gate_paths_1", int'(PathsReady), 1);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b1);
    chk("gate_paths_0", int'(PathsReady), 0);

    // Gate mode, two complete paths buffered before draining.
    for (int k = 0; k < 8; k++) cycle(1'b1, W'(16'h00C0 + k), 1'b0, 1'b1);
    chk("two_paths_ready", int'(PathsReady), 2);
    chk("two_paths_occ", int'(Occupancy), 8);
    chk("two_paths_full", int'(InAccept), 0);
    pdSeen = 0;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    chk("two_paths_done", pdSeen, 2);

    // Overflow in stream mode; full write concurrent with a pop is accepted.
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b1, W'(16'h00D0 + k), 1'b0, 1'b0);
    cycle(1'b1, 16'h00D8, 1'b1, 1'b0);
    chk("full_pop_occ", int'(Occupancy), 8);
    chk("full_pop_noovf", int'(Overflow), 0);
    cycle(1'b1, 16'h00D9, 1'b0, 1'b0);
    chk("ovf_set", int'(Overflow), 1);
    chk("ovf_occ", int'(Occupancy), 8);
`ifdef PATH_READ_BUFFER_HWM_EN
    chk("hwm_peak", int'(HighWater), 8);
`endif
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_sticky", int'(Overflow), 1);

    // Reset mid-path discards the partial path; a fresh path then completes.
    doReset();
    cycle(1'b1, 16'h00E0, 1'b0, 1'b0);
    cycle(1'b1, 16'h00E1, 1'b0, 1'b0);
    doReset();
    chk("midrst_occ", int'(Occupancy), 0);
    pdSeen = 0;
    for (int k = 0; k < 4; k++) cycle(1'b1, W'(16'h00F0 + k), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("midrst_path_done", pdSeen, 1);

    // Mode latch: toggling GateMode mid-path keeps stream release.
    cycle(1'b1, 16'h0110, 1'b0, 1'b0);
    cycle(1'b1, 16'h0111, 1'b0, 1'b1);
    chk("latch_still_stream", int'(OutValid), 1);
    cycle(1'b1, 16'h0112, 1'b0, 1'b1);
    cycle(1'b1, 16'h0113, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0120, 1'b1, 1'b1);
    chk("latch_now_gate", int'(OutValid), 0);
    for (int k = 1; k < 4; k++) cycle(1'b1, W'(16'h0120 + k), 1'b1, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);

    // Randomised traffic against the model.
    gm = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) gm = ~gm;
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0, gm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
